// File: rtl/mmu_pkg.sv
// Shared definitions for the MMU front-end: default element width and
// the activation feeder's sequencing states.
package mmu_pkg;

    localparam int DEFAULT_DATA_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } feeder_state_e;

endpackage

// File: rtl/skew_delay_line.sv
// Fixed-latency shift line used to delay one array row by DEPTH cycles.
// DEPTH=0 collapses to a plain wire.
module skew_delay_line
    import mmu_pkg::*;
#(
    parameter int DEPTH = 1,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    generate
        if (DEPTH == 0) begin : g_wire
            assign q_o = d_i;
        end else begin : g_regs
            logic [WIDTH-1:0] stage_q [DEPTH];

            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
                end else begin
                    stage_q[0] <= d_i;
                    for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
                end
            end

            assign q_o = stage_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/act_skew_feeder.sv
// Buffers activation vectors and feeds the PE array rows with a diagonal
// skew, leaving an all-idle gap after each tile for shadow-weight promotion.
module act_skew_feeder
    import mmu_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ROWS       = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ROWS*DATA_WIDTH-1:0] in_data,
    input  logic                       in_last,
    output logic [ROWS-1:0]            out_en,
    output logic [ROWS*DATA_WIDTH-1:0] out_data,
    output logic                       busy,
    output logic                       done
);

    localparam int VEC_W = ROWS * DATA_WIDTH;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(ROWS);

    logic [VEC_W:0]   fifoMem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wrPtr_q, rdPtr_q;
    logic [PTR_W:0]   count_q;
    logic             fifoFull, fifoEmpty, push, pop;
    logic [VEC_W:0]   head;

    feeder_state_e    state_q, state_d;
    logic [CNT_W-1:0] drainCnt_q, drainCnt_d;
    logic             done_q, done_d;

    logic             stage0En_q;
    logic [VEC_W-1:0] stage0Data_q;
    logic [DATA_WIDTH:0] rowTap [ROWS];

    // Readiness comes only from the registered count, so a full FIFO stays
    // closed even in a cycle where it is also popped.
    assign fifoFull  = (count_q == (PTR_W+1)'(FIFO_DEPTH));
    assign fifoEmpty = (count_q == '0);
    assign in_ready  = rstn && !fifoFull;
    assign push      = in_valid && in_ready;
    assign head      = fifoMem_q[rdPtr_q];

    always_ff @(posedge clk) begin
        if (push) fifoMem_q[wrPtr_q] <= {in_last, in_data};
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (push) wrPtr_q <= wrPtr_q + PTR_W'(1);
            if (pop)  rdPtr_q <= rdPtr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + (PTR_W+1)'(1);
                2'b01:   count_q <= count_q - (PTR_W+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            drainCnt_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            drainCnt_q <= drainCnt_d;
            done_q     <= done_d;
        end
    end

    // DRAIN holds off pops for ROWS cycles so the last vector reaches the
    // bottom row before the next tile can start.
    always_comb begin
        state_d    = state_q;
        drainCnt_d = drainCnt_q;
        done_d     = 1'b0;
        pop        = 1'b0;
        case (state_q)
            IDLE, STREAM: begin
                if (!fifoEmpty) begin
                    pop        = 1'b1;
                    drainCnt_d = '0;
                    state_d    = head[VEC_W] ? DRAIN : STREAM;
                end
            end
            DRAIN: begin
                if (drainCnt_q == CNT_W'(ROWS - 1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    drainCnt_d = drainCnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Data is held on bubbles, so every delayed row also holds its value.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stage0En_q   <= 1'b0;
            stage0Data_q <= '0;
        end else begin
            stage0En_q <= pop;
            if (pop) stage0Data_q <= head[VEC_W-1:0];
        end
    end

    assign rowTap[0] = {stage0En_q, stage0Data_q[0 +: DATA_WIDTH]};

    generate
        for (genvar r = 1; r < ROWS; r++) begin : g_row
            skew_delay_line #(
                .DEPTH (r),
                .WIDTH (DATA_WIDTH + 1)
            ) u_delay (
                .clk  (clk),
                .rstn (rstn),
                .d_i  ({stage0En_q, stage0Data_q[r*DATA_WIDTH +: DATA_WIDTH]}),
                .q_o  (rowTap[r])
            );
        end
    endgenerate

    always_comb begin
        out_en   = '0;
        out_data = '0;
        for (int r = 0; r < ROWS; r++) begin
            out_en[r]                          = rowTap[r][DATA_WIDTH];
            out_data[r*DATA_WIDTH +: DATA_WIDTH] = rowTap[r][DATA_WIDTH-1:0];
        end
    end

    assign done = done_q;
    assign busy = (state_q != IDLE) || !fifoEmpty || done_q;

endmodule
